// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter controller: FSM encoding and default widths.
package counter_ctrl_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int PRESC_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler: counts 0..term while enabled and pulses tick on the terminal value.
module tick_gen
    import counter_ctrl_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] term,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick = en && (cnt_q == term);

    // Holding the value while disabled is what lets a pause resume mid-period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Programmable up/down counter with prescaler, periodic/one-shot modes and hold.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode,
    input  logic               dir,
    input  logic [WIDTH-1:0]   limit,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               busy,
    output logic               done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               tc_q, tc_d;
    logic               mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    logic               start_ok;
    logic               tick_en;
    logic               tick;
    logic               terminal;

    assign start_ok = start && !stop;
    assign tick_en  = (state_q == ST_RUN) && !hold;

    tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (start || stop),
        .term  (presc_q),
        .tick  (tick)
    );

    assign terminal = dir_q ? (count_q == '0) : (count_q == limit_q);

    // Priority: stop, then start, then the per-state behaviour.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        mode_d  = mode_q;
        dir_d   = dir_q;
        limit_d = limit_q;
        presc_d = presc_q;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start_ok) begin
            state_d = ST_RUN;
            mode_d  = mode;
            dir_d   = dir;
            limit_d = limit;
            presc_d = presc;
            count_d = dir ? limit : '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hold) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (terminal) begin
                            tc_d = 1'b1;
                            if (mode_q) begin
                                state_d = ST_DONE;
                            end else begin
                                count_d = dir_q ? limit_q : '0;
                            end
                        end else begin
                            count_d = dir_q ? count_q - ONE : count_q + ONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!hold) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            limit_q <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: vector table plus hold and reset sequences.
module tb_counter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        hold;
    logic        mode;
    logic        dir;
    logic [7:0]  limit;
    logic [23:0] presc;
    logic [7:0]  count;
    logic        tc;
    logic        busy;
    logic        done;

    int n_total;
    int n_pass;

    typedef struct {
        logic        start;
        logic        stop;
        logic        hold;
        logic        mode;
        logic        dir;
        logic [7:0]  limit;
        logic [23:0] presc;
        logic [7:0]  e_count;
        logic        e_tc;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    counter_ctrl #(
        .WIDTH   (8),
        .PRESC_W (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .hold  (hold),
        .mode  (mode),
        .dir   (dir),
        .limit (limit),
        .presc (presc),
        .count (count),
        .tc    (tc),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic st, input logic sp, input logic hd, input logic md,
                       input logic dr, input logic [7:0] lim, input logic [23:0] pre,
                       input logic [7:0] ec, input logic etc, input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.stop = sp; v.hold = hd; v.mode = md; v.dir = dr;
        v.limit = lim; v.presc = pre;
        v.e_count = ec; v.e_tc = etc; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    // Idle-cycle vector: no start/stop, configuration inputs set to junk that must be ignored.
    task automatic addj(input logic hd, input logic [7:0] ec, input logic etc,
                        input logic eb, input logic ed);
        add(1'b0, 1'b0, hd, 1'b1, 1'b1, 8'd200, 24'd3, ec, etc, eb, ed);
    endtask

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b busy=%0b done=%0b",
                     name, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic hd, input logic md,
                         input logic dr, input logic [7:0] lim, input logic [23:0] pre);
        start = st; stop = sp; hold = hd; mode = md; dir = dr; limit = lim; presc = pre;
    endtask

    task automatic cycle_check(input string name, input logic [7:0] ec, input logic etc,
                               input logic eb, input logic ed);
        @(posedge clk);
        #1;
        check(name, {count, tc, busy, done}, {ec, etc, eb, ed});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 8'd0, 24'd0);

        // up periodic, limit 3, presc 0
        add(1,0,0,0,0,8'd3,24'd0, 8'd0,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd2,0,1,0);
        addj(0, 8'd3,0,1,0);
        addj(0, 8'd0,1,1,0);
        addj(0, 8'd1,0,1,0);
        add(0,1,0,0,0,8'd0,24'd0, 8'd0,0,0,0);
        // down one-shot, limit 2, presc 1
        add(1,0,0,1,1,8'd2,24'd1, 8'd2,0,1,0);
        addj(0, 8'd2,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd0,0,1,0);
        addj(0, 8'd0,0,1,0);
        addj(0, 8'd0,1,0,1);
        addj(0, 8'd0,0,0,1);
        addj(0, 8'd0,0,0,1);
        // limit 0 periodic
        add(1,0,0,0,0,8'd0,24'd0, 8'd0,0,1,0);
        addj(0, 8'd0,1,1,0);
        addj(0, 8'd0,1,1,0);
        add(0,1,0,0,0,8'd0,24'd0, 8'd0,0,0,0);
        // down periodic, limit 2
        add(1,0,0,0,1,8'd2,24'd0, 8'd2,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd0,0,1,0);
        addj(0, 8'd2,1,1,0);
        addj(0, 8'd1,0,1,0);
        // start and stop together: stop wins
        add(1,1,0,0,0,8'd5,24'd0, 8'd0,0,0,0);
        // restart while running reloads with the new limit
        add(1,0,0,0,0,8'd5,24'd0, 8'd0,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd2,0,1,0);
        add(1,0,0,0,0,8'd1,24'd0, 8'd0,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd0,1,1,0);
        add(0,1,0,0,0,8'd0,24'd0, 8'd0,0,0,0);
        // up one-shot, limit 1, then restart out of DONE
        add(1,0,0,1,0,8'd1,24'd0, 8'd0,0,1,0);
        addj(0, 8'd1,0,1,0);
        addj(0, 8'd1,1,0,1);
        addj(0, 8'd1,0,0,1);
        add(1,0,0,0,0,8'd2,24'd0, 8'd0,0,1,0);
        addj(0, 8'd1,0,1,0);
        add(0,1,0,0,0,8'd0,24'd0, 8'd0,0,0,0);
        // hold freezes the prescaler mid-period (presc 2)
        add(1,0,0,0,0,8'd7,24'd2, 8'd0,0,1,0);
        addj(0, 8'd0,0,1,0);
        addj(1, 8'd0,0,1,0);
        addj(1, 8'd0,0,1,0);
        addj(1, 8'd0,0,1,0);
        addj(0, 8'd0,0,1,0);
        addj(0, 8'd0,0,1,0);
        addj(0, 8'd1,0,1,0);
        add(0,1,0,0,0,8'd0,24'd0, 8'd0,0,0,0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {count, tc, busy, done}, 11'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].hold, vecs[i].mode,
                  vecs[i].dir, vecs[i].limit, vecs[i].presc);
            cycle_check($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tc,
                        vecs[i].e_busy, vecs[i].e_done);
        end

        // hold for 5 cycles at count 2, presc 0
        drive(1, 0, 0, 0, 0, 8'd7, 24'd0);
        cycle_check("hold_start", 8'd0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 8'd7, 24'd0);
        cycle_check("hold_c1", 8'd1, 0, 1, 0);
        cycle_check("hold_c2", 8'd2, 0, 1, 0);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle_check($sformatf("hold_frozen%0d", k), 8'd2, 0, 1, 0);
        end
        hold = 1'b0;
        cycle_check("hold_resume", 8'd2, 0, 1, 0);
        cycle_check("hold_next", 8'd3, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 8'd0, 24'd0);
        cycle_check("hold_stop", 8'd0, 0, 0, 0);

        // asynchronous reset at count 5
        drive(1, 0, 0, 0, 0, 8'd9, 24'd0);
        cycle_check("rst_start", 8'd0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 8'd9, 24'd0);
        for (int k = 1; k <= 5; k++) begin
            cycle_check($sformatf("rst_run%0d", k), 8'(k), 0, 1, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {count, tc, busy, done}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle_check($sformatf("rst_idle%0d", k), 8'd0, 0, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 8'd4, 24'd0);
        cycle_check("rst_restart", 8'd0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 8'd4, 24'd0);
        cycle_check("rst_restart_c1", 8'd1, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits.
REQ-002 Parameter PRESC_W, default 24, prescaler width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request: latch configuration and (re)start counting.
REQ-006 stop  input  1  single-cycle request: abort and return to IDLE.
REQ-007 hold  input  1  level signal: freeze counting while high in RUN.
REQ-008 mode  input  1  0 = periodic (wrap), 1 = one-shot.
REQ-009 dir  input  1  0 = count up, 1 = count down.
REQ-010 limit  input  WIDTH  terminal value.
REQ-011 presc  input  PRESC_W  divider; count advances once every presc+1 clk cycles.
REQ-012 count  output  WIDTH  current count, registered.
REQ-013 tc  output  1  one-cycle pulse on terminal count, registered.
REQ-014 busy  output  1  high in RUN or PAUSE.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-017 mode, dir, limit and presc are latched into shadow registers only on an accepted start; changes at other times have no effect.
REQ-018 Accepted start (any state, stop low): next cycle state = RUN, count = 0 if dir=0 else limit, prescaler cleared, tc = 0.
REQ-019 stop high (any state): next cycle state = IDLE, count = 0, tc = 0; stop wins over a simultaneous start.
REQ-020 Tick: prescaler counts 0..presc_shadow; a tick occurs in the cycle the prescaler equals presc_shadow and is in RUN; the prescaler then returns to 0.
REQ-021 presc = 0: a tick occurs every RUN cycle; the first count change appears presc+1 cycles after entering RUN.
REQ-022 Up, tick, count != limit: count increments by 1.
REQ-023 Up, tick, count == limit: tc pulses; periodic -> count = 0, stay in RUN; one-shot -> count holds limit, state = DONE.
REQ-024 Down, tick, count != 0: count decrements by 1.
REQ-025 Down, tick, count == 0: tc pulses; periodic -> count = limit, stay in RUN; one-shot -> count holds 0, state = DONE.
REQ-026 limit = 0: every tick is terminal; count stays 0; tc pulses on every tick in periodic mode.
REQ-027 RUN with hold high -> PAUSE: count and prescaler frozen; no ticks; no tc.
REQ-028 PAUSE with hold low -> RUN: the prescaler resumes from its frozen value.
REQ-029 DONE: count holds its value and done = 1 until start or stop.
REQ-030 tc is high for exactly one cycle per terminal event and is never high outside RUN-originated ticks.
REQ-031 count never leaves the range 0..limit_shadow; all arithmetic is modulo 2^WIDTH, with no carry out.

Reset
REQ-032 rst_n low asynchronously forces state = IDLE, count = 0, tc = 0, busy = 0, done = 0, prescaler = 0, and all shadow registers = 0.
REQ-033 Reset asserted mid-operation discards the operation; after release the block waits in IDLE for start.

Structure
REQ-034 Package counter_ctrl_pkg holds the FSM state encoding and the WIDTH/PRESC_W default constants.
REQ-035 Sub-module tick_gen (prescaler with enable, clear and terminal value inputs) produces the tick; counter_ctrl owns the FSM and count register.

Verification
REQ-036 Up periodic: limit=3, presc=0, start -> count 0,1,2,3,0,1; tc high in the cycle count returns to 0; busy=1.
REQ-037 Down one-shot: limit=2, presc=1, start -> count 2,2,1,1,0,0, then tc pulse, done=1, count held at 0.
REQ-038 Hold: up, presc=0, hold high for 5 cycles at count=2 -> count stays 2 and busy stays 1; after release, counting resumes at 3.
REQ-039 Simultaneous start and stop in RUN -> IDLE, count=0; start alone in RUN reloads count to 0 with the new limit.
REQ-040 limit=0, periodic, presc=0 -> count=0 and tc high every cycle in RUN.
REQ-041 rst_n pulsed low mid-RUN at count=5 -> all outputs 0 immediately, without a clock edge; state remains IDLE after release.
